// File: rtl/drp_reconf_if.sv
// Handshake and bus bundle between the DRP reconfiguration controller and
// the PLL DRP port / configuration table ROM / requester.
interface drp_reconf_if;
   logic        START;
   logic [2:0]  TBL_IDX;
   logic [6:0]  TBL_ADDR;
   logic [15:0] TBL_MASK;
   logic [15:0] TBL_DATA;
   logic        TBL_LAST;
   logic [6:0]  DADDR;
   logic        DEN;
   logic        DWE;
   logic [15:0] DI;
   logic [15:0] DO;
   logic        DRDY;
   logic        PLL_RST;
   logic        LOCKED;
   logic        BUSY;
   logic        DONE;
   logic        ERROR;

   modport master (
      input  START, TBL_ADDR, TBL_MASK, TBL_DATA, TBL_LAST, DO, DRDY, LOCKED,
      output TBL_IDX, DADDR, DEN, DWE, DI, PLL_RST, BUSY, DONE, ERROR
   );

   modport slave (
      output START, TBL_ADDR, TBL_MASK, TBL_DATA, TBL_LAST, DO, DRDY, LOCKED,
      input  TBL_IDX, DADDR, DEN, DWE, DI, PLL_RST, BUSY, DONE, ERROR
   );
endinterface

// File: rtl/drp_reconf_ctrl.sv
// PLL reconfiguration over DRP: holds PLL reset, walks a table of masked
// read-modify-write entries, releases reset and waits for lock.
module drp_reconf_ctrl #(
   parameter int DRDY_TIMEOUT = 64,
   parameter int LOCK_TIMEOUT = 4096,
   parameter int RST_HOLD     = 4
) (
   input  logic         DCLK,
   input  logic         RST,
   drp_reconf_if.master bus
);

   localparam int CNT_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT)
                          ? ((LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD)
                          : ((DRDY_TIMEOUT > RST_HOLD) ? DRDY_TIMEOUT : RST_HOLD);
   localparam int CW = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TIMEOUT - 1);
   localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      HOLD_RST  = 4'd1,
      RD_REQ    = 4'd2,
      RD_WAIT   = 4'd3,
      WR_REQ    = 4'd4,
      WR_WAIT   = 4'd5,
      NEXT      = 4'd6,
      RELEASE   = 4'd7,
      WAIT_LOCK = 4'd8
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          saw_low_q, saw_low_d;
   logic          last_q, last_d;
   logic [6:0]    daddr_q, daddr_d;
   logic [15:0]   di_q, di_d;
   logic          pll_rst_q, pll_rst_d;
   logic          busy_q;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic          den_s, dwe_s;

   // Masked merge: mask bits keep the value read back from the PLL.
   function automatic logic [15:0] merge_bits(input logic [15:0] rd,
                                              input logic [15:0] mask,
                                              input logic [15:0] data);
      return (rd & mask) | (data & ~mask);
   endfunction

   // Next-state, DRP strobes and per-state register updates.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      saw_low_d = saw_low_q;
      last_d    = last_q;
      daddr_d   = daddr_q;
      di_d      = di_q;
      pll_rst_d = pll_rst_q;
      done_d    = 1'b0;
      error_d   = error_q;
      den_s     = 1'b0;
      dwe_s     = 1'b0;

      case (state_q)
         IDLE: begin
            pll_rst_d = 1'b0;
            if (bus.START && bus.DRDY) begin
               state_d   = HOLD_RST;
               idx_d     = 3'd0;
               cnt_d     = '0;
               pll_rst_d = 1'b1;
               error_d   = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         HOLD_RST: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = RD_REQ;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         RD_REQ, WR_REQ: begin
            // The strobe is gated by DRDY in the same cycle, so it can never
            // be issued into a busy port.
            if (bus.DRDY) begin
               den_s     = 1'b1;
               dwe_s     = (state_q == WR_REQ);
               saw_low_d = 1'b0;
               cnt_d     = '0;
               if (state_q == RD_REQ) begin
                  daddr_d = bus.TBL_ADDR;
                  state_d = RD_WAIT;
               end else begin
                  state_d = WR_WAIT;
               end
            end else if (cnt_q == DRDY_LAST) begin
               error_d = 1'b1;
               state_d = RELEASE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (bus.DRDY && saw_low_q) begin
               cnt_d = '0;
               if (state_q == RD_WAIT) begin
                  di_d    = merge_bits(bus.DO, bus.TBL_MASK, bus.TBL_DATA);
                  last_d  = bus.TBL_LAST;
                  state_d = WR_REQ;
               end else begin
                  state_d = NEXT;
               end
            end else if (cnt_q == DRDY_LAST) begin
               error_d = 1'b1;
               state_d = RELEASE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
               if (!bus.DRDY) begin
                  saw_low_d = 1'b1;
               end else begin
                  saw_low_d = saw_low_q;
               end
            end
         end
         NEXT: begin
            cnt_d = '0;
            if (last_q || (idx_q == 3'd7)) begin
               state_d = RELEASE;
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = RD_REQ;
            end
         end
         RELEASE: begin
            pll_rst_d = 1'b0;
            cnt_d     = '0;
            state_d   = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            // An aborted table walk still waits for lock but never reports DONE.
            if (bus.LOCKED) begin
               done_d  = ~error_q;
               state_d = IDLE;
            end else if (cnt_q == LOCK_LAST) begin
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d   = IDLE;
            pll_rst_d = 1'b1;
         end
      endcase
   end

   // State and output registers; RST forces the safe idle configuration.
   always_ff @(posedge DCLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         idx_q     <= 3'd0;
         cnt_q     <= '0;
         saw_low_q <= 1'b0;
         last_q    <= 1'b0;
         daddr_q   <= 7'd0;
         di_q      <= 16'd0;
         pll_rst_q <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         saw_low_q <= saw_low_d;
         last_q    <= last_d;
         daddr_q   <= daddr_d;
         di_q      <= di_d;
         pll_rst_q <= pll_rst_d;
         busy_q    <= (state_d != IDLE);
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   assign bus.TBL_IDX = idx_q;
   assign bus.DADDR   = (state_q == RD_REQ) ? bus.TBL_ADDR : daddr_q;
   assign bus.DEN     = den_s;
   assign bus.DWE     = dwe_s;
   assign bus.DI      = di_q;
   assign bus.PLL_RST = pll_rst_q;
   assign bus.BUSY    = busy_q;
   assign bus.DONE    = done_q;
   assign bus.ERROR   = error_q;

endmodule

// File: tb/tb_drp_reconf_ctrl.sv
// Directed bench for drp_reconf_ctrl: table ROM, PLL DRP/lock model,
// single-entry vector table plus multi-cycle corner-case sequences.
module tb_drp_reconf_ctrl;
   logic DCLK = 1'b0;
   logic RST  = 1'b1;

   drp_reconf_if bus();

   drp_reconf_ctrl #(.DRDY_TIMEOUT(64), .LOCK_TIMEOUT(4096), .RST_HOLD(4)) dut (
      .DCLK (DCLK),
      .RST  (RST),
      .bus  (bus)
   );

   always #5 DCLK = ~DCLK;

   logic [6:0]  rom_addr [8];
   logic [15:0] rom_mask [8];
   logic [15:0] rom_data [8];
   logic        rom_last [8];
   logic [15:0] rd_value = 16'h0000;

   assign bus.TBL_ADDR = rom_addr[bus.TBL_IDX];
   assign bus.TBL_MASK = rom_mask[bus.TBL_IDX];
   assign bus.TBL_DATA = rom_data[bus.TBL_IDX];
   assign bus.TBL_LAST = rom_last[bus.TBL_IDX];
   assign bus.DO       = rd_value;

   int drp_lat    = 2;
   bit drdy_hang  = 1'b0;
   int lock_delay = 10;
   bit lock_never = 1'b0;
   int drp_cnt    = 0;
   int lock_cnt   = 0;

   // PLL DRP port: DRDY drops after each DEN for drp_lat cycles.
   always @(posedge DCLK or posedge RST) begin
      if (RST) begin
         bus.DRDY <= 1'b1;
         drp_cnt  <= 0;
      end else if (bus.DEN) begin
         bus.DRDY <= 1'b0;
         drp_cnt  <= drp_lat;
      end else if (!drdy_hang && drp_cnt > 0) begin
         drp_cnt <= drp_cnt - 1;
         if (drp_cnt == 1) bus.DRDY <= 1'b1;
      end
   end

   // PLL lock: LOCKED rises lock_delay cycles after PLL_RST is released.
   always @(posedge DCLK or posedge RST) begin
      if (RST) begin
         bus.LOCKED <= 1'b0;
         lock_cnt   <= 0;
      end else if (bus.PLL_RST) begin
         bus.LOCKED <= 1'b0;
         lock_cnt   <= 0;
      end else if (!lock_never && lock_cnt >= lock_delay) begin
         bus.LOCKED <= 1'b1;
      end else begin
         lock_cnt <= lock_cnt + 1;
      end
   end

   int          n_acc = 0, done_cnt = 0, cyc = 0, rule_viol = 0;
   int          den_cyc = 0, err_rise = 0, pll_fall = 0, busy_fall = 0;
   logic        log_we   [64];
   logic [6:0]  log_addr [64];
   logic [15:0] log_di   [64];
   logic        den_prev = 1'b0, err_prev = 1'b0, pll_prev = 1'b1, busy_prev = 1'b0;

   // Mid-cycle monitor: DRP access log, DONE count, event timestamps, DEN rules.
   always @(negedge DCLK) begin
      cyc = cyc + 1;
      if (!RST) begin
         if (bus.DEN) begin
            if (n_acc < 64) begin
               log_we[n_acc]   = bus.DWE;
               log_addr[n_acc] = bus.DADDR;
               log_di[n_acc]   = bus.DI;
            end
            n_acc   = n_acc + 1;
            den_cyc = cyc;
            if (!bus.DRDY || den_prev || !bus.PLL_RST) rule_viol = rule_viol + 1;
         end
         if (bus.DONE) done_cnt = done_cnt + 1;
         if (bus.ERROR && !err_prev) err_rise = cyc;
         if (!bus.PLL_RST && pll_prev) pll_fall = cyc;
         if (!bus.BUSY && busy_prev) busy_fall = cyc;
      end
      den_prev  = bus.DEN;
      err_prev  = bus.ERROR;
      pll_prev  = bus.PLL_RST;
      busy_prev = bus.BUSY;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge DCLK);
      #1;
   endtask

   task automatic start_pulse();
      bus.START = 1'b1;
      tick(1);
      bus.START = 1'b0;
   endtask

   task automatic wait_idle(input int limit, input string name);
      int k = 0;
      while (bus.BUSY && k < limit) begin
         tick(1);
         k++;
      end
      check({name, "_busy_timeout"}, {31'd0, bus.BUSY}, 32'd0);
      tick(2);
   endtask

   function automatic logic [31:0] out_vec();
      return {bus.DEN, bus.DWE, bus.DADDR, bus.DI, bus.PLL_RST,
              bus.BUSY, bus.DONE, bus.ERROR, bus.TBL_IDX};
   endfunction

   localparam logic [31:0] RST_VEC = {1'b0, 1'b0, 7'h00, 16'h0000, 1'b1,
                                      1'b0, 1'b0, 1'b0, 3'd0};

   typedef struct {
      logic [6:0]  addr;
      logic [15:0] mask;
      logic [15:0] data;
      logic [15:0] rdv;
      logic [15:0] exp_di;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int base, dbase, bad;
      bus.START = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rom_addr[i] = 7'h00;
         rom_mask[i] = 16'h0000;
         rom_data[i] = 16'h0000;
         rom_last[i] = 1'b1;
      end
      vecs[0] = '{7'h08, 16'hF000, 16'h0041, 16'hA123, 16'hA041};
      vecs[1] = '{7'h21, 16'h0000, 16'h1234, 16'hFFFF, 16'h1234};
      vecs[2] = '{7'h7F, 16'hFFFF, 16'h5555, 16'h0F0F, 16'h0F0F};
      vecs[3] = '{7'h00, 16'h00FF, 16'hABCD, 16'h1234, 16'hAB34};
      vecs[4] = '{7'h55, 16'hAAAA, 16'hFFFF, 16'h0000, 16'h5555};

      tick(3);
      check("reset_outputs", out_vec(), RST_VEC);
      RST = 1'b0;
      tick(1);
      check("pll_rst_drop_after_reset", {31'd0, bus.PLL_RST}, 32'd0);

      for (int i = 0; i < 5; i++) begin
         rom_addr[0] = vecs[i].addr;
         rom_mask[0] = vecs[i].mask;
         rom_data[0] = vecs[i].data;
         rom_last[0] = 1'b1;
         rd_value    = vecs[i].rdv;
         base  = n_acc;
         dbase = done_cnt;
         start_pulse();
         wait_idle(200, $sformatf("vec%0d", i));
         check($sformatf("vec%0d_acc_count", i), n_acc - base, 32'd2);
         check($sformatf("vec%0d_read", i), {log_we[base], log_addr[base]}, {1'b0, vecs[i].addr});
         check($sformatf("vec%0d_write", i), {log_we[base+1], log_addr[base+1]}, {1'b1, vecs[i].addr});
         check($sformatf("vec%0d_di", i), log_di[base+1], vecs[i].exp_di);
         check($sformatf("vec%0d_done", i), done_cnt - dbase, 32'd1);
         check($sformatf("vec%0d_error", i), {31'd0, bus.ERROR}, 32'd0);
      end

      // Three-entry table ending on entry 2.
      for (int i = 0; i < 3; i++) begin
         rom_addr[i] = 7'h14 + 7'(i);
         rom_mask[i] = 16'h0000;
         rom_data[i] = 16'h1111 * 16'(i + 1);
         rom_last[i] = (i == 2);
      end
      base  = n_acc;
      dbase = done_cnt;
      start_pulse();
      wait_idle(300, "three");
      check("three_acc_count", n_acc - base, 32'd6);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("three_acc%0d", k), {log_we[base+k], log_addr[base+k]},
               {1'(k % 2), 7'h14 + 7'(k / 2)});
      end
      check("three_w15_di", log_di[base+3], 32'h2222);
      check("three_done", done_cnt - dbase, 32'd1);

      // DRDY stuck low after the first read strobe.
      rom_addr[0] = 7'h0A;
      rom_last[0] = 1'b1;
      drdy_hang = 1'b1;
      base  = n_acc;
      dbase = done_cnt;
      start_pulse();
      wait_idle(400, "hang");
      check("hang_error", {31'd0, bus.ERROR}, 32'd1);
      check("hang_pll_rst", {31'd0, bus.PLL_RST}, 32'd0);
      check("hang_no_done", done_cnt - dbase, 32'd0);
      check("hang_only_read", n_acc - base, 32'd1);
      check("hang_err_latency", err_rise - den_cyc, 32'd65);
      check("hang_pll_latency", pll_fall - den_cyc, 32'd66);
      drdy_hang = 1'b0;
      tick(5);

      // LOCKED never rises: lock timeout, then the next START clears ERROR.
      lock_never = 1'b1;
      dbase = done_cnt;
      start_pulse();
      check("lock_start_clears_error", {31'd0, bus.ERROR}, 32'd0);
      wait_idle(5000, "lock");
      check("lock_error", {31'd0, bus.ERROR}, 32'd1);
      check("lock_no_done", done_cnt - dbase, 32'd0);
      check("lock_busy_latency", busy_fall - pll_fall, 32'd4096);
      check("lock_err_latency", err_rise - pll_fall, 32'd4096);
      lock_never = 1'b0;
      dbase = done_cnt;
      start_pulse();
      check("restart_clears_error", {31'd0, bus.ERROR}, 32'd0);
      wait_idle(200, "restart");
      check("restart_done", done_cnt - dbase, 32'd1);

      // RST in the middle of a write access.
      rom_addr[0] = 7'h33;
      rom_last[0] = 1'b0;
      rom_addr[1] = 7'h34;
      rom_last[1] = 1'b1;
      drp_lat = 20;
      dbase = done_cnt;
      start_pulse();
      bad = 1;
      for (int k = 0; k < 100 && bad == 1; k++) begin
         if (bus.DEN && bus.DWE) bad = 0;
         else tick(1);
      end
      check("rst_mid_write_seen", bad, 32'd0);
      tick(1);
      RST = 1'b1;
      #1;
      check("rst_mid_outputs", out_vec(), RST_VEC);
      @(posedge DCLK);
      #1;
      RST = 1'b0;
      drp_lat = 2;
      tick(2);
      check("rst_mid_no_done", done_cnt - dbase, 32'd0);
      base  = n_acc;
      dbase = done_cnt;
      start_pulse();
      wait_idle(300, "after_rst");
      check("after_rst_acc_count", n_acc - base, 32'd4);
      check("after_rst_first", {log_we[base], log_addr[base]}, {1'b0, 7'h33});
      check("after_rst_third", {log_we[base+2], log_addr[base+2]}, {1'b0, 7'h34});
      check("after_rst_done", done_cnt - dbase, 32'd1);

      // No TBL_LAST anywhere, plus a START while busy.
      for (int i = 0; i < 8; i++) begin
         rom_addr[i] = 7'h40 + 7'(i);
         rom_mask[i] = 16'hFFFF;
         rom_last[i] = 1'b0;
      end
      base  = n_acc;
      dbase = done_cnt;
      start_pulse();
      tick(20);
      start_pulse();
      wait_idle(2000, "eight");
      check("eight_acc_count", n_acc - base, 32'd16);
      bad = 0;
      for (int k = 0; k < 16; k++) begin
         if ({log_we[base+k], log_addr[base+k]} !== {1'(k % 2), 7'h40 + 7'(k / 2)}) bad++;
      end
      check("eight_order_errors", bad, 32'd0);
      check("eight_idx_final", {29'd0, bus.TBL_IDX}, 32'd7);
      check("eight_done", done_cnt - dbase, 32'd1);

      check("den_rule_violations", rule_viol, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
